// File: rtl/genscope_mon.sv
// ============================================================================
// Module   : genscope_mon
// Purpose  : Monitors a 4-bit genscope count, classifies each step and posts
//            wrap/error records on a valid/ready port.
// Option   : GENSCOPE_MON_DIR_CHECK_EN enables the GEN direction check.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module genscope_mon #(
    parameter int GEN    = 1,
    parameter int WRAP_W = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CLR,
    input  logic [3:0]        Q_IN,
    output logic              EV_VALID,
    input  logic              EV_READY,
    output logic [WRAP_W+1:0] EV_DATA,
    output logic [WRAP_W-1:0] WRAP_CNT,
    output logic              ERR,
    output logic              OVF,
    output logic [1:0]        STATE
);

    typedef enum logic [1:0] {
        S_INIT  = 2'b00,
        S_TRACK = 2'b01,
        S_ERR   = 2'b10
    } state_t;

    localparam logic [1:0]        c_KIND_UP  = 2'b01;
    localparam logic [1:0]        c_KIND_DN  = 2'b10;
    localparam logic [1:0]        c_KIND_ERR = 2'b11;
    localparam logic [WRAP_W-1:0] c_ONE      = {{(WRAP_W-1){1'b0}}, 1'b1};

    state_t              r_state_q,    w_state_d;
    logic [3:0]          r_prev_q,     w_prev_d;
    logic                r_ev_valid_q, w_ev_valid_d;
    logic [WRAP_W+1:0]   r_ev_data_q,  w_ev_data_d;
    logic [WRAP_W-1:0]   r_wrap_cnt_q, w_wrap_cnt_d;
    logic                r_err_q,      w_err_d;
    logic                r_ovf_q,      w_ovf_d;

    logic [3:0]          w_delta;
    logic [WRAP_W-1:0]   w_wrap_inc;
    logic                w_up_bad;
    logic                w_dn_bad;
    logic                w_bad;
    logic                w_new_ev;
    logic [WRAP_W+1:0]   w_new_rec;

    always_comb begin
        w_state_d    = r_state_q;
        w_prev_d     = Q_IN;
        w_ev_valid_d = r_ev_valid_q;
        w_ev_data_d  = r_ev_data_q;
        w_wrap_cnt_d = r_wrap_cnt_q;
        w_err_d      = r_err_q;
        w_ovf_d      = r_ovf_q;
        w_bad        = 1'b0;
        w_new_ev     = 1'b0;
        w_new_rec    = '0;
        w_delta      = Q_IN - r_prev_q;
        w_wrap_inc   = (&r_wrap_cnt_q) ? r_wrap_cnt_q : r_wrap_cnt_q + c_ONE;
`ifdef GENSCOPE_MON_DIR_CHECK_EN
        w_up_bad     = (GEN == 1);
        w_dn_bad     = (GEN == 0);
`else
        w_up_bad     = 1'b0;
        w_dn_bad     = 1'b0;
`endif

        case (r_state_q)
            S_INIT: w_state_d = S_TRACK;
            S_TRACK: begin
                case (w_delta)
                    4'h0: ;
                    4'h1: begin
                        if (w_up_bad) begin
                            w_bad = 1'b1;
                        end else if (r_prev_q == 4'hF) begin
                            w_wrap_cnt_d = w_wrap_inc;
                            w_new_ev     = 1'b1;
                            w_new_rec    = {c_KIND_UP, w_wrap_inc};
                        end
                    end
                    4'hF: begin
                        if (w_dn_bad) begin
                            w_bad = 1'b1;
                        end else if (r_prev_q == 4'h0) begin
                            w_wrap_cnt_d = w_wrap_inc;
                            w_new_ev     = 1'b1;
                            w_new_rec    = {c_KIND_DN, w_wrap_inc};
                        end
                    end
                    default: w_bad = 1'b1;
                endcase
                if (w_bad) begin
                    w_new_ev  = 1'b1;
                    w_new_rec = {c_KIND_ERR, r_wrap_cnt_q};
                    w_err_d   = 1'b1;
                    w_state_d = S_ERR;
                end
            end
            default: ;
        endcase

        // A record is only replaced once the consumer has taken the old one.
        if (w_new_ev) begin
            if (!r_ev_valid_q || EV_READY) begin
                w_ev_valid_d = 1'b1;
                w_ev_data_d  = w_new_rec;
            end else begin
                w_ovf_d = 1'b1;
            end
        end else if (r_ev_valid_q && EV_READY) begin
            w_ev_valid_d = 1'b0;
        end

        if (CLR) begin
            w_state_d    = S_INIT;
            w_prev_d     = 4'h0;
            w_ev_valid_d = 1'b0;
            w_ev_data_d  = '0;
            w_wrap_cnt_d = '0;
            w_err_d      = 1'b0;
            w_ovf_d      = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state_q    <= S_INIT;
            r_prev_q     <= 4'h0;
            r_ev_valid_q <= 1'b0;
            r_ev_data_q  <= '0;
            r_wrap_cnt_q <= '0;
            r_err_q      <= 1'b0;
            r_ovf_q      <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_prev_q     <= w_prev_d;
            r_ev_valid_q <= w_ev_valid_d;
            r_ev_data_q  <= w_ev_data_d;
            r_wrap_cnt_q <= w_wrap_cnt_d;
            r_err_q      <= w_err_d;
            r_ovf_q      <= w_ovf_d;
        end
    end

    assign EV_VALID = r_ev_valid_q;
    assign EV_DATA  = r_ev_data_q;
    assign WRAP_CNT = r_wrap_cnt_q;
    assign ERR      = r_err_q;
    assign OVF      = r_ovf_q;
    assign STATE    = r_state_q;

endmodule

`default_nettype wire

// File: tb/tb_genscope_mon.sv
// ============================================================================
// Module   : tb_genscope_mon
// Purpose  : Self-checking bench for genscope_mon (two configurations).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_genscope_mon;

    localparam int W0   = 8;
    localparam int W1   = 2;
    localparam int GEN0 = 1;
    localparam int GEN1 = 0;
`ifdef GENSCOPE_MON_DIR_CHECK_EN
    localparam bit DIRCHK = 1'b1;
`else
    localparam bit DIRCHK = 1'b0;
`endif

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          clr      = 1'b0;
    logic          ev_ready = 1'b0;
    logic [3:0]    q_in     = 4'h0;

    logic          ev_valid0, err0, ovf0;
    logic [W0+1:0] ev_data0;
    logic [W0-1:0] wrap0;
    logic [1:0]    state0;
    logic          ev_valid1, err1, ovf1;
    logic [W1+1:0] ev_data1;
    logic [W1-1:0] wrap1;
    logic [1:0]    state1;

    always #5 clk = ~clk;

    genscope_mon #(.GEN(GEN0), .WRAP_W(W0)) u_dut0 (
        .CLK(clk), .RST_N(rst_n), .CLR(clr), .Q_IN(q_in),
        .EV_VALID(ev_valid0), .EV_READY(ev_ready), .EV_DATA(ev_data0),
        .WRAP_CNT(wrap0), .ERR(err0), .OVF(ovf0), .STATE(state0)
    );

    genscope_mon #(.GEN(GEN1), .WRAP_W(W1)) u_dut1 (
        .CLK(clk), .RST_N(rst_n), .CLR(clr), .Q_IN(q_in),
        .EV_VALID(ev_valid1), .EV_READY(ev_ready), .EV_DATA(ev_data1),
        .WRAP_CNT(wrap1), .ERR(err1), .OVF(ovf1), .STATE(state1)
    );

    // Reference model: st 0=init 1=track 2=err; record held as (kind, cnt).
    typedef struct {
        int st;
        int prev;
        bit valid;
        int kind;
        int cnt;
        int wrap;
        bit err;
        bit ovf;
    } mdl_t;

    mdl_t m0, m1;
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic mdl_t mreset();
        mdl_t m;
        m.st = 0; m.prev = 0; m.valid = 1'b0; m.kind = 0; m.cnt = 0;
        m.wrap = 0; m.err = 1'b0; m.ovf = 1'b0;
        return m;
    endfunction

    function automatic mdl_t mstep(mdl_t m, int q, bit c, bit rdy, int gen, int maxc);
        mdl_t n;
        bit   ev   = 1'b0;
        bit   bad  = 1'b0;
        int   kind = 0;
        int   cnt  = 0;
        int   d;
        if (c) return mreset();
        n = m;
        d = (q - m.prev + 16) % 16;
        if (m.st == 0) begin
            n.st = 1;
        end else if (m.st == 1) begin
            if (d == 1) begin
                if (DIRCHK && gen == 1) bad = 1'b1;
                else if (m.prev == 15) begin
                    n.wrap = (m.wrap < maxc) ? m.wrap + 1 : maxc;
                    ev = 1'b1; kind = 1; cnt = n.wrap;
                end
            end else if (d == 15) begin
                if (DIRCHK && gen == 0) bad = 1'b1;
                else if (m.prev == 0) begin
                    n.wrap = (m.wrap < maxc) ? m.wrap + 1 : maxc;
                    ev = 1'b1; kind = 2; cnt = n.wrap;
                end
            end else if (d != 0) begin
                bad = 1'b1;
            end
            if (bad) begin
                ev = 1'b1; kind = 3; cnt = m.wrap;
                n.err = 1'b1; n.st = 2;
            end
        end
        n.prev = q;
        if (ev) begin
            if (!m.valid || rdy) begin
                n.valid = 1'b1; n.kind = kind; n.cnt = cnt;
            end else begin
                n.ovf = 1'b1;
            end
        end else if (m.valid && rdy) begin
            n.valid = 1'b0;
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("d0_valid", 32'(ev_valid0), 32'(m0.valid));
        check("d0_data",  32'(ev_data0),  32'((m0.kind << W0) | m0.cnt));
        check("d0_wrap",  32'(wrap0),     32'(m0.wrap));
        check("d0_err",   32'(err0),      32'(m0.err));
        check("d0_ovf",   32'(ovf0),      32'(m0.ovf));
        check("d0_state", 32'(state0),    32'(m0.st));
        check("d1_valid", 32'(ev_valid1), 32'(m1.valid));
        check("d1_data",  32'(ev_data1),  32'((m1.kind << W1) | m1.cnt));
        check("d1_wrap",  32'(wrap1),     32'(m1.wrap));
        check("d1_err",   32'(err1),      32'(m1.err));
        check("d1_ovf",   32'(ovf1),      32'(m1.ovf));
        check("d1_state", 32'(state1),    32'(m1.st));
    endtask

    // Called at a falling edge: apply inputs, advance models, compare after the next rising edge.
    task automatic cyc(input int q, input bit c, input bit rdy);
        q_in     = 4'(q);
        clr      = c;
        ev_ready = rdy;
        m0 = mstep(m0, q, c, rdy, GEN0, (1 << W0) - 1);
        m1 = mstep(m1, q, c, rdy, GEN1, (1 << W1) - 1);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int cur_q;
        int r;
        m0 = mreset();
        m1 = mreset();
        #1;
        @(negedge clk);
        compare_all();
        check("t1_reset_state", 32'(state0), 32'd0);
        rst_n = 1'b1;

        // Hold, then leave INIT
        cyc(5, 1'b0, 1'b1);
        check("t1_track", 32'(state0), 32'd1);
        cyc(5, 1'b0, 1'b1);
        cyc(5, 1'b0, 1'b1);
        check("t1_no_event", 32'(ev_valid0), 32'd0);
        check("t1_wrap0", 32'(wrap0), 32'd0);

        // Count down through a wrap
        for (int v = 4; v >= 0; v--) cyc(v, 1'b0, 1'b1);
        cyc(15, 1'b0, 1'b1);
        check("t2_valid", 32'(ev_valid0), 32'd1);
        check("t2_data", 32'(ev_data0), 32'h201);
        check("t2_wrap", 32'(wrap0), 32'd1);
        cyc(14, 1'b0, 1'b1);
        check("t2_pulse", 32'(ev_valid0), 32'd0);

        // Illegal jump, sticky ERR, clear
        for (int v = 13; v >= 3; v--) cyc(v, 1'b0, 1'b1);
        cyc(7, 1'b0, 1'b1);
        check("t3_err", 32'(err0), 32'd1);
        check("t3_data", 32'(ev_data0), 32'h301);
        check("t3_state", 32'(state0), 32'd2);
        for (int v = 6; v >= 0; v--) cyc(v, 1'b0, 1'b1);
        cyc(15, 1'b0, 1'b1);
        check("t3_no_wrap_ev", 32'(ev_valid0), 32'd0);
        check("t3_wrap_frozen", 32'(wrap0), 32'd1);
        cyc(15, 1'b1, 1'b1);
        check("t3_clr_data", 32'(ev_data0), 32'd0);
        check("t3_clr_state", 32'(state0), 32'd0);

        // Back-pressure: second wrap dropped
        cyc(0, 1'b0, 1'b0);
        cyc(15, 1'b0, 1'b0);
        check("t4_first", 32'(ev_data0), 32'h201);
        for (int v = 14; v >= 0; v--) cyc(v, 1'b0, 1'b0);
        cyc(15, 1'b0, 1'b0);
        check("t4_held", 32'(ev_data0), 32'h201);
        check("t4_ovf", 32'(ovf0), 32'd1);
        check("t4_still_valid", 32'(ev_valid0), 32'd1);
        cyc(15, 1'b0, 1'b1);
        check("t4_accept", 32'(ev_valid0), 32'd0);

        // Saturation on the 2-bit instance
        cyc(0, 1'b1, 1'b1);
        cyc(0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            for (int v = 1; v <= 15; v++) cyc(v, 1'b0, 1'b1);
            cyc(0, 1'b0, 1'b1);
        end
        check("t5_sat", 32'(wrap1), 32'd3);
        check("t5_data", 32'(ev_data1), 32'h7);
        check("t5_valid", 32'(ev_valid1), 32'd1);

        // Direction check
        cyc(0, 1'b1, 1'b1);
        cyc(4, 1'b0, 1'b1);
        cyc(4, 1'b0, 1'b1);
        cyc(5, 1'b0, 1'b1);
        check("t6_dir_err", 32'(err0), 32'(DIRCHK));
        check("t6_dir_ev", 32'(ev_valid0), 32'(DIRCHK));

        // Asynchronous reset while a record is pending
        cyc(0, 1'b1, 1'b0);
        cyc(0, 1'b0, 1'b0);
        cyc(15, 1'b0, 1'b0);
        check("t6_pending", 32'(ev_valid0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_rst0", 32'(ev_valid0), 32'd0);
        check("t6_async_rst1", 32'(ev_valid1), 32'd0);
        m0 = mreset();
        m1 = mreset();
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // Randomized traffic
        cur_q = 0;
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 40)      cur_q = (cur_q + 1) % 16;
            else if (r < 80) cur_q = (cur_q + 15) % 16;
            else if (r < 93) cur_q = cur_q;
            else             cur_q = int'($urandom_range(0, 15));
            cyc(cur_q, ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) < 6));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
